// File: rtl/dvsd_div_pkg.sv
// Shared definitions for the 16-by-8 restoring divider.
//   DIV_NW    : default dividend / quotient width
//   DIV_DW    : default divisor / remainder width
//   div_state_e : control FSM states
//   cnt_width() : width of the iteration counter for a given dividend width
package dvsd_div_pkg;

  localparam int DIV_NW = 16;
  localparam int DIV_DW = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } div_state_e;

  // The counter only has to reach NW-1, so log2(NW) bits suffice.
  function automatic int cnt_width(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/dvsd_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, then subtract the divisor if it fits.
// Ports:
//   pr_i      : partial remainder from the previous iteration (DW+1 bits)
//   bit_i     : next dividend bit, MSB first
//   divisor_i : divisor
//   pr_o      : updated partial remainder
//   qbit_o    : quotient bit produced by this iteration
module dvsd_div_step #(
  parameter int DW = 8
) (
  input  logic [DW:0]   pr_i,
  input  logic          bit_i,
  input  logic [DW-1:0] divisor_i,
  output logic [DW:0]   pr_o,
  output logic          qbit_o
);

  logic [DW+1:0] shifted;
  logic          fits;

  always_comb begin
    // Full-width shift keeps every incoming bit visible to the compare; the
    // restoring invariant pr < divisor guarantees the result fits in DW+1.
    shifted = {pr_i, bit_i};
    fits    = (shifted >= {2'b00, divisor_i});
    qbit_o  = fits;
    if (fits) begin
      pr_o = (DW+1)'(shifted - {2'b00, divisor_i});
    end else begin
      pr_o = (DW+1)'(shifted);
    end
  end

endmodule

// File: rtl/dvsd_16d8_div.sv
// Sequential unsigned divider, one quotient bit per clock (restoring
// algorithm). Inverse of the 8x8 multiplier: product / operand -> operand.
// Ports:
//   clock    : rising-edge clock
//   resetn   : asynchronous active-low reset
//   start    : request, accepted only while idle
//   dividend : numerator, captured on accepted start
//   divisor  : denominator, captured on accepted start
//   busy     : division in progress
//   done     : one-cycle pulse when q/r/dbz have been updated
//   q, r     : quotient and remainder of the last completed division
//   dbz      : last completed division had a zero divisor
module dvsd_16d8_div
  import dvsd_div_pkg::*;
#(
  parameter int NW = DIV_NW,
  parameter int DW = DIV_DW
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          start,
  input  logic [NW-1:0] dividend,
  input  logic [DW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [NW-1:0] q,
  output logic [DW-1:0] r,
  output logic          dbz
);

  localparam int CW = cnt_width(NW);
  localparam logic [CW-1:0] LAST_CNT = CW'(NW - 1);

  div_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  // Holds the unconsumed dividend bits at the top and the quotient bits
  // collected so far at the bottom; after NW shifts it is the quotient.
  logic [NW-1:0] dvd_q, dvd_d;
  logic [DW-1:0] dvs_q, dvs_d;
  logic [DW:0]   pr_q, pr_d;
  logic [NW-1:0] q_q, q_d;
  logic [DW-1:0] r_q, r_d;
  logic          dbz_q, dbz_d;
  logic          done_q, done_d;

  logic [DW:0]   step_pr;
  logic          step_qbit;

  dvsd_div_step #(
    .DW (DW)
  ) u_step (
    .pr_i      (pr_q),
    .bit_i     (dvd_q[NW-1]),
    .divisor_i (dvs_q),
    .pr_o      (step_pr),
    .qbit_o    (step_qbit)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      pr_q    <= '0;
      q_q     <= '0;
      r_q     <= '0;
      dbz_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      pr_q    <= pr_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dbz_q   <= dbz_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    pr_d    = pr_q;
    q_d     = q_q;
    r_d     = r_q;
    dbz_d   = dbz_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          dvd_d   = dividend;
          dvs_d   = divisor;
          pr_d    = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        if (dvs_q == '0) begin
          // Zero divisor: skip the iterations and report saturated quotient,
          // low dividend byte as remainder.
          q_d     = '1;
          r_d     = dvd_q[DW-1:0];
          dbz_d   = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          pr_d  = step_pr;
          dvd_d = {dvd_q[NW-2:0], step_qbit};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            q_d     = {dvd_q[NW-2:0], step_qbit};
            r_d     = step_pr[DW-1:0];
            dbz_d   = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy = (state_q == RUN);
  assign done = done_q;
  assign q    = q_q;
  assign r    = r_q;
  assign dbz  = dbz_q;

endmodule

// File: tb/tb_dvsd_16d8_div.sv
module tb_dvsd_16d8_div;

  logic        clock;
  logic        resetn;
  logic        start;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        busy;
  logic        done;
  logic [15:0] q;
  logic [7:0]  r;
  logic        dbz;

  int checks = 0;
  int errors = 0;

  dvsd_16d8_div dut (
    .clock    (clock),
    .resetn   (resetn),
    .start    (start),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .q        (q),
    .r        (r),
    .dbz      (dbz)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic [15:0] a;
    logic [7:0]  b;
    logic [15:0] exp_q;
    logic [7:0]  exp_r;
    logic        exp_dbz;
    int          exp_lat;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Issue one division and wait (bounded) for done; lat = edges after the
  // accepting edge, or -1 if done never came.
  task automatic run_div(input logic [15:0] a, input logic [7:0] b,
                         output logic [15:0] gq, output logic [7:0] gr,
                         output logic gdbz, output int lat);
    @(negedge clock);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    lat   = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clock);
      #1;
      if (done) begin
        lat = i;
        break;
      end
    end
    gq   = q;
    gr   = r;
    gdbz = dbz;
  endtask

  initial begin
    logic [15:0] gq;
    logic [7:0]  gr;
    logic        gdbz;
    int          lat;
    int          a, b;
    int          done_idx[$];
    int          done_cnt;

    vecs[0] = '{"150x150",   16'd22500, 8'd150, 16'd150,   8'd0,    1'b0, 16};
    vecs[1] = '{"255x255",   16'd65025, 8'd255, 16'd255,   8'd0,    1'b0, 16};
    vecs[2] = '{"max_by_1",  16'd65535, 8'd1,   16'd65535, 8'd0,    1'b0, 16};
    vecs[3] = '{"1000_by_7", 16'd1000,  8'd7,   16'd142,   8'd6,    1'b0, 16};
    vecs[4] = '{"by_zero",   16'd1234,  8'd0,   16'hFFFF,  8'hD2,   1'b1, 1};
    vecs[5] = '{"100_by_10", 16'd100,   8'd10,  16'd10,    8'd0,    1'b0, 16};
    vecs[6] = '{"7_by_200",  16'd7,     8'd200, 16'd0,     8'd7,    1'b0, 16};

    resetn   = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_q",    32'(q),    32'd0);
    chk("rst_r",    32'(r),    32'd0);
    chk("rst_dbz",  32'(dbz),  32'd0);
    @(negedge clock);
    resetn = 1'b1;

    // Directed table
    for (int i = 0; i < 7; i++) begin
      run_div(vecs[i].a, vecs[i].b, gq, gr, gdbz, lat);
      chk({vecs[i].name, "_q"},   32'(gq),   32'(vecs[i].exp_q));
      chk({vecs[i].name, "_r"},   32'(gr),   32'(vecs[i].exp_r));
      chk({vecs[i].name, "_dbz"}, 32'(gdbz), 32'(vecs[i].exp_dbz));
      chk({vecs[i].name, "_lat"}, 32'(lat),  32'(vecs[i].exp_lat));
      @(posedge clock);
      #1;
      chk({vecs[i].name, "_done_one_cycle"}, 32'(done), 32'd0);
    end

    // Multiplier products divided back by one operand
    for (int i = 0; i < 6; i++) begin
      a = int'($urandom_range(0, 255));
      b = int'($urandom_range(1, 255));
      run_div(16'(a * b), 8'(b), gq, gr, gdbz, lat);
      chk("prod_q",   32'(gq),   32'(a));
      chk("prod_r",   32'(gr),   32'd0);
      chk("prod_dbz", 32'(gdbz), 32'd0);
    end

    // Establish a known held result, then start a run and poke start mid-run
    run_div(16'd100, 8'd10, gq, gr, gdbz, lat);
    chk("pre_ign_q", 32'(gq), 32'd10);
    @(negedge clock);
    dividend = 16'd1000;
    divisor  = 8'd7;
    start    = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    chk("ign_busy", 32'(busy), 32'd1);
    repeat (4) @(posedge clock);
    @(negedge clock);
    dividend = 16'd500;
    divisor  = 8'd3;
    start    = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    chk("ign_q_held", 32'(q), 32'd10);
    lat = -1;
    for (int i = 6; i <= 40; i++) begin
      @(posedge clock);
      #1;
      if (done) begin
        lat = i;
        break;
      end
    end
    chk("ign_lat", 32'(lat), 32'd16);
    chk("ign_q",   32'(q),   32'd142);
    chk("ign_r",   32'(r),   32'd6);
    @(posedge clock);
    #1;
    chk("ign_no_queue_busy", 32'(busy), 32'd0);
    chk("ign_no_queue_done", 32'(done), 32'd0);

    // Back-to-back with start held high
    @(negedge clock);
    dividend = 16'd22500;
    divisor  = 8'd150;
    start    = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clock);
      #1;
      if (done) done_idx.push_back(i);
    end
    start = 1'b0;
    chk("b2b_count", 32'(done_idx.size()), 32'd3);
    if (done_idx.size() == 3) begin
      chk("b2b_first", 32'(done_idx[0]), 32'd17);
      chk("b2b_gap1",  32'(done_idx[1] - done_idx[0]), 32'd17);
      chk("b2b_gap2",  32'(done_idx[2] - done_idx[1]), 32'd17);
    end
    chk("b2b_q", 32'(q), 32'd150);
    for (int i = 0; i < 40; i++) begin
      if (!busy) break;
      @(posedge clock);
      #1;
    end
    chk("b2b_drain", 32'(busy), 32'd0);

    // Reset mid-run
    @(negedge clock);
    dividend = 16'd65535;
    divisor  = 8'd1;
    start    = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (8) @(posedge clock);
    #2;
    resetn = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_q",    32'(q),    32'd0);
    chk("mid_rst_r",    32'(r),    32'd0);
    chk("mid_rst_dbz",  32'(dbz),  32'd0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    resetn = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clock);
      #1;
      if (done || busy) done_cnt++;
    end
    chk("mid_rst_no_done", 32'(done_cnt), 32'd0);

    run_div(16'd200, 8'd9, gq, gr, gdbz, lat);
    chk("post_rst_q",   32'(gq),  32'd22);
    chk("post_rst_r",   32'(gr),  32'd2);
    chk("post_rst_lat", 32'(lat), 32'd16);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dvsd_16d8_div.md
# dvsd_16d8_div

Sequential 16-by-8 unsigned divider: the inverse of the 8x8 array multiplier, so a product `m` can be divided back by one operand to recover the other. It uses restoring division, one quotient bit per clock, behind a start/busy/done handshake. It sits beside the multiplier in the datapath as the self-check and inverse-operation unit.

## Interface
- `NW`, 16, dividend and quotient width
- `DW`, 8, divisor and remainder width
- `clock`  in  1  single rising-edge clock
- `resetn`  in  1  asynchronous, active-low reset
- `start`  in  1  request; sampled only when idle
- `dividend`  in  NW  unsigned numerator, captured on accepted start
- `divisor`  in  DW  unsigned denominator, captured on accepted start
- `busy`  out  1  high while a division is in progress
- `done`  out  1  one-cycle pulse; results valid from this cycle on
- `q`  out  NW  quotient
- `r`  out  DW  remainder
- `dbz`  out  1  divide-by-zero flag for the last result

## Operation
- States: `IDLE`, `RUN`.
- In `IDLE`, `start=1` is accepted:
  - Captures `dividend` and `divisor`.
  - Clears the partial remainder (DW+1 bits) and the bit counter.
  - Moves to `RUN`; `busy` rises.
- If the captured divisor is 0:
  - No iterations run; the FSM returns to `IDLE` on the next edge.
  - Outputs: `q=all ones`, `r=dividend[DW-1:0]`, `dbz=1`, `done=1`.
- Each `RUN` cycle, MSB first:
  - `pr = {pr[DW-1:0], next dividend bit}`.
  - If `pr >= divisor`, then `pr -= divisor` and the quotient bit is 1; otherwise the quotient bit is 0.
- After NW iterations:
  - Registers `q` and `r=pr[DW-1:0]`; `dbz=0`, `done=1`.
  - Returns to `IDLE`.
- `q`, `r` and `dbz` hold their values until the next accepted start completes. They do not change while `busy` is high.
- `start` while `busy=1` is ignored: no queueing, no corruption.
- `start` high in the same cycle as `done` is accepted, because the FSM is already in `IDLE`.
- Arithmetic is unsigned only. The invariant `dividend == q*divisor + r`, with `r < divisor`, holds whenever `divisor != 0`.
- Reset (`resetn=0`) at any time, including mid-`RUN`:
  - Immediately forces `IDLE`.
  - `busy=0`, `done=0`, `q=0`, `r=0`, `dbz=0`, internal registers 0.
  - The operation in flight is discarded.

## Timing
- Reset values of all outputs are 0.
- Start accepted at edge N:
  - `busy=1` from after edge N.
  - Normal divide: `done=1` and results valid after edge N+NW (N+16), for exactly one cycle. `busy` falls at that same edge.
  - Divide-by-zero: `done` after edge N+1.
- Throughput: one division per NW+1 cycles when `start` is held high.
- All outputs are registered; there is no combinational path from inputs to outputs.
- `resetn` assertion is asynchronous. Deassertion is synchronized externally; the block assumes a clean release.

## Structure
- Shared package `dvsd_div_pkg`:
  - `NW` and `DW` defaults.
  - State enum (`IDLE`, `RUN`).
  - Counter width `$clog2(NW)`.
- Sub-module `dvsd_div_step`: combinational compare-and-subtract.
  - Inputs: `pr`, incoming bit, `divisor`.
  - Outputs: next `pr` and quotient bit.
  - Instantiated once in the top level, which holds the FSM, counter and result registers.
- Expected RTL size: about 150–200 lines total.

## Test plan
- 22500 / 150 (150×150): q=150, r=0, dbz=0; `done` exactly 16 cycles after the accepting edge.
- 65025 / 255 and 65535 / 1: q=255, r=0; q=65535, r=0.
- 1000 / 7: q=142, r=6. Then feed multiplier products from random a, b (b≠0) and check q=a, r=0.
- 1234 / 0: `done` after 1 cycle, q=16'hFFFF, r=8'hD2, dbz=1. Next 100 / 10 gives q=10, r=0, dbz=0.
- Protocol checks:
  - Pulse `start` with new operands at cycle 5 of a `RUN`: it is ignored and the original result is unaffected.
  - Back-to-back: `start` held high produces `done` every 17 cycles.
- Reset checks:
  - Drop `resetn` at cycle 8 of a `RUN`: all outputs are 0 immediately and no `done` appears.
  - After release, 200 / 9 gives q=22, r=2.
